mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multicycle MIPS main controller: sequences fetch/decode/execute and drives the shared datapath.
- Produces the 3-bit ALU control consumed by the ALU (010 add, 110 sub, 000 and, 001 or, 111 slt) and consumes its zero flag for branch resolution.
- Handshakes with a unified instruction/data memory via mem_ready.

Parameters:
- STATE_W, 4, width of the state register / state debug output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- op  input  6  instruction[31:26], sampled from IR in DECODE.
- funct  input  6  instruction[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- alu_ctrl  output  3  ALU operation code.
- alu_src_a  output  1  0=PC, 1=regA.
- alu_src_b  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_en  output  1  PC write enable (Mealy).
- i_or_d  output  1  0=PC address, 1=ALUOut address.
- mem_read, mem_write  output  1 each  memory strobes.
- ir_write  output  1  IR load (Mealy on mem_ready).
- reg_write, reg_dst, mem_to_reg  output  1 each  register-file controls; reg_dst 1=rd, 0=rt.
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal  output  1  high in HALT.
- state  output  STATE_W  current state, for debug.

Behaviour:
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, HALT 15. Unlisted codes go to HALT.
- Reset: async to FETCH. While rst_n=0, every enable/strobe (pc_en, ir_write, mem_read, mem_write, reg_write, instr_done) is forced to 0. Muxes and alu_ctrl show FETCH values. A reset mid-instruction abandons it with no further writes.
- Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00. ir_write=pc_en=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by op:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - otherwise -> HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Wait on mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait on mem_ready. instr_done=mem_ready. Go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> HALT, with no register write.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01. pc_en=zero for beq, pc_en=~zero for bne. instr_done=1. Go to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Go to FETCH.
- HALT: illegal=1, all enables 0. Only rst_n exits HALT.
- Latency with mem_ready=1 in the same cycle (FETCH to instr_done inclusive):
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - beq/bne/j 3 cycles
  - each mem_ready=0 cycle adds one.
- mem_read and mem_write are never high together. pc_en and ir_write are never high without mem_ready in FETCH.

Optional Feature:
- Macro MC_ITYPE_ALU_EN. When defined, DECODE maps op 001000 (addi) and 001010 (slti) to I_EXEC.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=010 for addi, 111 for slti.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH. Total 4 cycles.
- Without the macro: both opcodes go to HALT, and I_EXEC/I_WB are not implemented (codes 10/11 go to HALT).

Test Plan:
- lw (op=100011), mem_ready low for 2 cycles in FETCH and 1 in MEM_RD -> states 0,0,0,1,2,3,3,4,0; ir_write and pc_en pulse exactly once in FETCH; reg_write=1 only in MEM_WB; 8 cycles total.
- R-type op=0, funct=101010 -> alu_ctrl=111 in R_EXEC; R_WB reg_write=1, reg_dst=1; instr_done asserted on cycle 4.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_en=0. Both give alu_ctrl=110 and return to FETCH.
- op=111111 -> DECODE then HALT; illegal=1 and all enables 0 for 20 cycles; rst_n pulse low -> FETCH, illegal=0.
- Assert rst_n=0 asynchronously mid-MEM_WR, with mem_write high -> mem_write drops without waiting for a clock edge; state=0 after release; no instr_done.
- addi op=001000 -> I_EXEC/I_WB with reg_write in I_WB when MC_ITYPE_ALU_EN is defined; HALT when it is not.

Source files
------------

// File: rtl/mc_ctrl_unit_if.sv
// Control/status bundle between the multicycle MIPS controller (master)
// and the shared datapath plus unified memory (slave).
interface mc_ctrl_unit_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read,
           mem_write, ir_write, reg_write, reg_dst, mem_to_reg, instr_done, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read,
           mem_write, ir_write, reg_write, reg_dst, mem_to_reg, instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS main controller: fetch/decode/execute sequencing for the shared datapath.
// Optional addi/slti support is compiled in with `define MC_ITYPE_ALU_EN.
module mc_ctrl_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_ctrl_unit_if.master     bus,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ITYPE_ALU_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

  state_t cur, nxt;

  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    alu_ctrl   = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = 3'b010;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
        if (bus.mem_ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = 3'b010;
        case (bus.op)
          OP_RTYPE:      nxt = R_EXEC;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_J:          nxt = JUMP;
`ifdef MC_ITYPE_ALU_EN
          OP_ADDI, OP_SLTI: nxt = I_EXEC;
`endif
          default:       nxt = HALT;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = 3'b010;
        nxt       = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = bus.mem_ready;
        if (bus.mem_ready) nxt = FETCH;
      end
      // An unsupported funct is trapped here, before any register write.
      R_EXEC: begin
        alu_src_a = 1'b1;
        nxt       = R_WB;
        case (bus.funct)
          6'b100000: alu_ctrl = 3'b010;
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default:   nxt = HALT;
        endcase
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = 3'b110;
        pc_src     = 2'b01;
        pc_en      = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
`ifdef MC_ITYPE_ALU_EN
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = (bus.op == OP_SLTI) ? 3'b111 : 3'b010;
        nxt       = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
`endif
      HALT: begin
        illegal = 1'b1;
        nxt     = HALT;
      end
      default: nxt = HALT;
    endcase
    // Strobes must die the instant reset asserts, not at the next edge.
    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_src     = pc_src;
  assign bus.pc_en      = pc_en;
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;
  assign state          = STATE_W'(cur);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: random instruction stream with random memory stalls,
// expectations derived per instruction from the controller's cycle-level behaviour.
`timescale 1ns/1ps
module tb_mc_ctrl_unit;
  localparam int STATE_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [STATE_W-1:0] state;

  mc_ctrl_unit_if bus ();

  mc_ctrl_unit #(.STATE_W(STATE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .state (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cycles;
    logic [127:0] trace;
    int           ir_w;
    int           pc_e;
    int           reg_w;
    int           m_rd;
    int           m_wr;
    logic [5:0]   exec;
    logic [1:0]   wb;
    logic [1:0]   psrc;
    logic         ends_illegal;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual === required) passed++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
  endtask

  function automatic void step(inout exp_t e, input int code, input bit rdy);
    e.trace = {e.trace[123:0], 4'(code)};
    e.cycles++;
    rdy_q.push_back(rdy);
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // Reference: one instruction as a list of per-cycle state codes plus what it must write.
  function automatic exp_t build(input logic [5:0] op, input logic [5:0] funct, input logic z,
                                 input int fs, input int ms);
    exp_t e;
    logic [2:0] alu;
    bit legal;
    e = '{default: 0};
    rdy_q.delete();
    for (int i = 0; i < fs; i++) step(e, 0, 1'b0);
    step(e, 0, 1'b1);
    e.ir_w = 1;
    e.pc_e = 1;
    e.m_rd = fs + 1;
    step(e, 1, rnd());
    if (op == 6'b100011) begin
      step(e, 2, rnd());
      for (int i = 0; i < ms; i++) step(e, 3, 1'b0);
      step(e, 3, 1'b1);
      step(e, 4, rnd());
      e.m_rd += ms + 1;
      e.reg_w = 1;
      e.wb = 2'b01;
      e.exec = {1'b1, 2'b10, 3'b010};
    end else if (op == 6'b101011) begin
      step(e, 2, rnd());
      for (int i = 0; i < ms; i++) step(e, 5, 1'b0);
      step(e, 5, 1'b1);
      e.m_wr = ms + 1;
      e.exec = {1'b1, 2'b10, 3'b010};
    end else if (op == 6'b000000) begin
      legal = 1'b1;
      case (funct)
        6'b100000: alu = 3'b010;
        6'b100010: alu = 3'b110;
        6'b100100: alu = 3'b000;
        6'b100101: alu = 3'b001;
        6'b101010: alu = 3'b111;
        default: begin alu = 3'b000; legal = 1'b0; end
      endcase
      step(e, 6, rnd());
      e.exec = {1'b1, 2'b00, alu};
      if (legal) begin
        step(e, 7, rnd());
        e.reg_w = 1;
        e.wb = 2'b10;
      end else begin
        step(e, 15, rnd());
        e.ends_illegal = 1'b1;
      end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      step(e, 8, rnd());
      e.exec = {1'b1, 2'b00, 3'b110};
      if ((op == 6'b000100) ? z : !z) begin
        e.pc_e = 2;
        e.psrc = 2'b01;
      end
    end else if (op == 6'b000010) begin
      step(e, 9, rnd());
      e.pc_e = 2;
      e.psrc = 2'b10;
`ifdef MC_ITYPE_ALU_EN
    end else if (op == 6'b001000 || op == 6'b001010) begin
      step(e, 10, rnd());
      step(e, 11, rnd());
      e.reg_w = 1;
      e.exec = {1'b1, 2'b10, (op == 6'b001010) ? 3'b111 : 3'b010};
`endif
    end else begin
      step(e, 15, rnd());
      e.ends_illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_strobes",
                128'({bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done, state}),
                128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("release_state", 128'({bus.illegal, state}), 128'(0));
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct, input logic z,
                               input int fs, input int ms);
    exp_t e;
    e = build(op, funct, z, fs, ms);
    exp_q.push_back(e);
    bus.op = op;
    bus.funct = funct;
    bus.zero = z;
    foreach (rdy_q[i]) begin
      bus.mem_ready = rdy_q[i];
      @(posedge clk);
      #1;
    end
    if (e.ends_illegal) begin
      repeat (20) begin
        bus.mem_ready = rnd();
        bus.zero = rnd();
        @(posedge clk);
        #1;
      end
      pulseReset();
    end
  endtask

  task automatic swResetTest();
    bus.op = 6'b101011;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2 checkOutput("mw_before_reset", 128'({bus.mem_write, state}), 128'({1'b1, 4'd5}));
    rst_n = 1'b0;
    #1;
    checkOutput("mw_async_drop", 128'({bus.mem_write, bus.instr_done, state}), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("sw_abort_state", 128'(state), 128'(0));
  endtask

  initial begin : monitor
    int cyc, irw, pce, rw, mr, mw, ovl;
    logic [127:0] tr;
    logic [5:0] ex;
    logic [1:0] wb, ps;
    bit halted;
    exp_t e;
    cyc = 0; irw = 0; pce = 0; rw = 0; mr = 0; mw = 0; ovl = 0;
    tr = '0; ex = '0; wb = '0; ps = '0; halted = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || halted) begin
        if (rst_n)
          checkOutput("halt_quiet",
                      128'({bus.illegal, bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write,
                            bus.reg_write, bus.instr_done, state}),
                      128'({7'b1000000, 4'd15}));
        else halted = 1'b0;
        if (!rst_n) begin
          cyc = 0; irw = 0; pce = 0; rw = 0; mr = 0; mw = 0; ovl = 0;
          tr = '0; ex = '0; wb = '0; ps = '0;
        end
        continue;
      end
      cyc++;
      tr = {tr[123:0], state[3:0]};
      if (bus.ir_write) irw++;
      if (bus.pc_en) begin pce++; ps = bus.pc_src; end
      if (bus.reg_write) begin rw++; wb = {bus.reg_dst, bus.mem_to_reg}; end
      if (bus.mem_read) mr++;
      if (bus.mem_write) mw++;
      if (bus.mem_read && bus.mem_write) ovl++;
      if (bus.alu_src_a && !ex[5]) ex = {1'b1, bus.alu_src_b, bus.alu_ctrl};
      if (bus.instr_done || bus.illegal || (exp_q.size() != 0 && cyc > 200)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_end", 128'({bus.instr_done, bus.illegal}), 128'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("cycles", 128'(cyc), 128'(e.cycles));
          checkOutput("state_trace", tr, e.trace);
          checkOutput("ir_write_cnt", 128'(irw), 128'(e.ir_w));
          checkOutput("pc_en_cnt", 128'(pce), 128'(e.pc_e));
          checkOutput("pc_src", 128'(ps), 128'(e.psrc));
          checkOutput("reg_write_cnt", 128'(rw), 128'(e.reg_w));
          checkOutput("wb_ctrl", 128'(wb), 128'(e.wb));
          checkOutput("mem_read_cnt", 128'(mr), 128'(e.m_rd));
          checkOutput("mem_write_cnt", 128'(mw), 128'(e.m_wr));
          checkOutput("exec_alu", 128'(ex), 128'(e.exec));
          checkOutput("rd_wr_overlap", 128'(ovl), 128'(0));
          checkOutput("end_kind", 128'({bus.illegal, bus.instr_done}),
                      128'({e.ends_illegal, !e.ends_illegal}));
        end
        halted = bus.illegal;
        cyc = 0; irw = 0; pce = 0; rw = 0; mr = 0; mw = 0; ovl = 0;
        tr = '0; ex = '0; wb = '0; ps = '0;
      end
    end
  end

  initial begin : driver
    logic [5:0] op, funct;
    int sel;
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold",
                128'({bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                      bus.instr_done, bus.alu_src_b, bus.alu_ctrl, state}),
                128'({6'b000000, 2'b01, 3'b010, 4'd0}));
    rst_n = 1'b1;

    applyStimulus(6'b100011, 6'd17, 1'b0, 2, 1);
    applyStimulus(6'b000000, 6'b101010, 1'b0, 0, 0);
    applyStimulus(6'b000100, 6'd3, 1'b1, 0, 0);
    applyStimulus(6'b000101, 6'd3, 1'b1, 1, 0);
    applyStimulus(6'b000010, 6'd9, 1'b0, 0, 0);
    applyStimulus(6'b101011, 6'd0, 1'b0, 0, 2);
    applyStimulus(6'b000000, 6'b100010, 1'b0, 0, 0);
    swResetTest();
    applyStimulus(6'b001000, 6'd5, 1'b0, 0, 0);
    applyStimulus(6'b111111, 6'd0, 1'b0, 0, 0);
    applyStimulus(6'b000000, 6'b000111, 1'b0, 1, 0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      funct = 6'($urandom);
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 4))
            0: funct = 6'b100000;
            1: funct = 6'b100010;
            2: funct = 6'b100100;
            3: funct = 6'b100101;
            default: funct = 6'b101010;
          endcase
        end
        3: op = 6'b000100;
        4: op = 6'b000101;
        5: op = 6'b000010;
        6: op = 6'b001000;
        7: op = 6'b001010;
        8: op = 6'($urandom);
        default: op = 6'b000000;
      endcase
      applyStimulus(op, funct, logic'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end

    bus.mem_ready = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) checkOutput("drain", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
